graph_loader: RTL and testbench
===============================

// Module: graph_loader
// PURPOSE
//  Stage directly upstream of placement. Accepts a streamed edge list (src,dst) over valid/ready.
//  Sweep-clears pos_X/pos_Y RAMs and the grid RAM to -1 (unplaced/empty), then writes the eaData/ebData edge memories.
//  Reports the accepted edge count (placement's n_edge) and the first source node, which the placer seeds first.
// PARAMETERS
//  V        11  address bits of edge and position memories (node id range 0..2**V-1)
//  GRID_N   10  grid side; grid memory holds GRID_N*GRID_N cells
//  DW       32  data width of all memory words and stream fields
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   one-cycle pulse; starts a load from IDLE, DONE or ERR
//  edge_valid   in   1   edge beat valid
//  edge_ready   out  1   loader accepts a beat (registered)
//  edge_src     in   DW  source node id (signed)
//  edge_dst     in   DW  destination node id (signed)
//  edge_last    in   1   final beat of the list; qualified by edge_valid
//  we_ea/we_eb  out  1   edge memory write enables (always asserted together)
//  addr_e       out  DW  edge memory address = edge index
//  din_ea       out  DW  src written to edge memory A
//  din_eb       out  DW  dst written to edge memory B
//  we_pos       out  1   write enable for pos_X and pos_Y (shared)
//  addr_pos     out  DW  position address
//  din_pos      out  DW  always 32'hFFFF_FFFF
//  we_grid      out  1   grid write enable
//  addr_grid    out  DW  grid address
//  din_grid     out  DW  always 32'hFFFF_FFFF
//  busy         out  1   high in CLR and LOAD
//  done         out  1   held high in DONE
//  error        out  1   held high in ERR
//  edge_count   out  DW  edges written so far; final value is n_edge
//  first_node   out  DW  src of the first written edge; -1 if none
//  dropped      out  DW  self-loop beats discarded (0 unless macro)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0 except first_node=-1; memory contents undefined until next start.
//  IDLE --start--> CLR. DONE/ERR --start--> CLR; done/error/edge_count/dropped clear on that edge.
//  start during CLR or LOAD is ignored.
//  CLR: counter k = 0..D-1, where D = max(2**V, GRID_N*GRID_N); one write per cycle.
//   we_pos=1 while k<2**V (addr_pos=k); we_grid=1 while k<GRID_N*GRID_N (addr_grid=k).
//   After the k=D-1 write -> LOAD. With default parameters CLR lasts exactly 2048 cycles.
//  LOAD: edge_ready=1. A beat is accepted when edge_valid & edge_ready.
//   Accepted beat: same cycle registers we_ea=we_eb=1, addr_e=edge_count, din_ea=src, din_eb=dst.
//   The write appears on the outputs the next cycle; edge_count increments with it.
//   First written edge latches first_node=src.
//  Range check: src or dst <0 or >=2**V -> no write; ERR the next cycle; edge_ready drops.
//  Overflow: beat accepted with edge_count==2**V -> ERR, no write.
//  edge_last on an accepted legal beat -> DONE next cycle; edge_ready low from that cycle on.
//  done rises in the same cycle as the last write.
//  Error has priority over last. In DONE/ERR no memory writes occur and edge_ready=0.
//  edge_count is DW bits, unsigned, and never exceeds 2**V.
//  Reset mid-CLR or mid-LOAD: immediate return to IDLE with write enables low.
// CONFIGURATION
//  LOADER_SELFLOOP_DROP_EN defined:
//   A legal beat with src==dst is accepted but not written; dropped increments.
//   edge_count is unchanged. edge_last on such a beat still -> DONE.
//  Undefined: self-loops are written like any other edge; dropped is tied to 0.
// STRUCTURE
//  Shared package placement_pkg:
//   NODE_NONE = 32'hFFFF_FFFF, loader state enum {IDLE, CLR, LOAD, DONE, ERR}, DW.
//  One sub-module: graph_loader_clear (CLR sweep counter with pos/grid enable decode, done pulse).
// TESTING
//  Reset low mid-CLR at k=100 -> outputs zero, IDLE; next start re-sweeps from k=0.
//  start; full sweep -> 2048 pos writes, grid writes for k=0..99 only, all data -1; LOAD entered at cycle 2049.
//  Stream (3,7),(7,1),(1,3,last) with valid held -> ea={3,7,1}, eb={7,1,3}, edge_count=3, first_node=3, done.
//  Valid toggled every other cycle -> same memory image; no beat lost or duplicated.
//  Beat (5,2048) -> no write, error=1, edge_ready=0; then start -> CLR, error=0.
//  Beat (4,4) then (4,9,last): macro on -> edge_count=1, dropped=1; macro off -> edge_count=2.

Source files
------------

// File: rtl/placement_pkg.sv
// Shared definitions for the placement pipeline.
//   DW             : default data width of memory words and stream fields
//   NODE_NONE      : marker for an unplaced node / empty grid cell (-1)
//   loader_state_e : graph_loader control states
//   max_int        : elaboration-time helper used to size the clear sweep
package placement_pkg;

    localparam int DW = 32;
    localparam logic [31:0] NODE_NONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        DONE,
        ERR
    } loader_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/graph_loader_clear.sv
// Clear sweep for graph_loader: walks k = 0..D-1, D = max(2**V, GRID_N*GRID_N),
// one step per cycle, and decodes which of the position and grid memories
// take a write at each k.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start                begin a sweep at k=0 (only issued while idle)
//   we_pos, addr_pos     position write strobe/address, high while k < 2**V
//   we_grid, addr_grid   grid write strobe/address, high while k < GRID_N*GRID_N
//   sweep_done           high during the k=D-1 write (final sweep cycle)
module graph_loader_clear
    import placement_pkg::*;
#(
    parameter int V      = 11,
    parameter int GRID_N = 10,
    parameter int DW     = placement_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          we_pos,
    output logic [DW-1:0] addr_pos,
    output logic          we_grid,
    output logic [DW-1:0] addr_grid,
    output logic          sweep_done
);

    localparam int POS_N      = 1 << V;
    localparam int GRID_CELLS = GRID_N * GRID_N;
    localparam int DEPTH      = max_int(POS_N, GRID_CELLS);
    // One spare bit so the exclusive bounds below are representable.
    localparam int KW         = $clog2(DEPTH) + 1;

    localparam logic [KW-1:0] K_LAST   = KW'(DEPTH - 1);
    localparam logic [KW-1:0] POS_END  = KW'(POS_N);
    localparam logic [KW-1:0] GRID_END = KW'(GRID_CELLS);

    logic          active;
    logic [KW-1:0] k;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            k      <= '0;
        end else if (start) begin
            active <= 1'b1;
            k      <= '0;
        end else if (active) begin
            if (k == K_LAST) begin
                active <= 1'b0;
                k      <= '0;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

    assign we_pos     = active && (k < POS_END);
    assign we_grid    = active && (k < GRID_END);
    assign addr_pos   = we_pos  ? DW'(k) : '0;
    assign addr_grid  = we_grid ? DW'(k) : '0;
    assign sweep_done = active && (k == K_LAST);

endmodule

// File: rtl/graph_loader.sv
// Graph loader, the stage directly upstream of placement.
// On start it sweep-clears the pos_X/pos_Y and grid memories to -1, then
// accepts a streamed (src,dst) edge list and writes it into the eaData/ebData
// edge memories. Reports the edge count (placement's n_edge) and the first
// written source node, which the placer seeds first.
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   start                       one-cycle pulse, honoured in IDLE/DONE/ERR only
//   edge_valid/ready/src/dst/last  edge stream input
//   we_ea, we_eb, addr_e, din_ea, din_eb   edge memory write port (registered)
//   we_pos, addr_pos, din_pos   shared pos_X/pos_Y clear port
//   we_grid, addr_grid, din_grid   grid clear port
//   busy, done, error           status: CLR|LOAD, held in DONE, held in ERR
//   edge_count, first_node, dropped   load results
//   fsm_state                   current control state, for observation
// Optional build macro: LOADER_SELFLOOP_DROP_EN -- legal src==dst beats are
// accepted but not written and are counted in dropped. Without it self-loops
// are ordinary edges and dropped stays 0.
module graph_loader
    import placement_pkg::*;
#(
    parameter int V      = 11,
    parameter int GRID_N = 10,
    parameter int DW     = placement_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          edge_valid,
    output logic          edge_ready,
    input  logic [DW-1:0] edge_src,
    input  logic [DW-1:0] edge_dst,
    input  logic          edge_last,
    output logic          we_ea,
    output logic          we_eb,
    output logic [DW-1:0] addr_e,
    output logic [DW-1:0] din_ea,
    output logic [DW-1:0] din_eb,
    output logic          we_pos,
    output logic [DW-1:0] addr_pos,
    output logic [DW-1:0] din_pos,
    output logic          we_grid,
    output logic [DW-1:0] addr_grid,
    output logic [DW-1:0] din_grid,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] edge_count,
    output logic [DW-1:0] first_node,
    output logic [DW-1:0] dropped,
    output loader_state_e fsm_state
);

    localparam int POS_N = 1 << V;

    loader_state_e state, state_next;
    logic          clr_start, clr_done;
    logic          accept, in_range, overflow, self_loop;
    logic          do_write, do_drop;
    logic          we_e;

    graph_loader_clear #(
        .V      (V),
        .GRID_N (GRID_N),
        .DW     (DW)
    ) u_clear (
        .clk        (clk),
        .reset      (reset),
        .start      (clr_start),
        .we_pos     (we_pos),
        .addr_pos   (addr_pos),
        .we_grid    (we_grid),
        .addr_grid  (addr_grid),
        .sweep_done (clr_done)
    );

    // Handshake: a beat transfers on a rising edge where edge_valid and
    // edge_ready are both high; edge_src/edge_dst/edge_last are only looked
    // at on that edge. edge_ready is a flop that is high exactly while the
    // state is LOAD, so it falls in the cycle after a last or illegal beat.
    always_comb begin
        state_next = state;
        clr_start  = 1'b0;
        do_write   = 1'b0;
        do_drop    = 1'b0;
        accept     = edge_valid && edge_ready;
        // Signed ids: a clear upper field means 0 <= id < 2**V.
        in_range   = (edge_src[DW-1:V] == '0) && (edge_dst[DW-1:V] == '0);
        overflow   = (edge_count == DW'(POS_N));
`ifdef LOADER_SELFLOOP_DROP_EN
        self_loop  = (edge_src == edge_dst);
`else
        self_loop  = 1'b0;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = CLR;
                    clr_start  = 1'b1;
                end
            end
            CLR: begin
                if (clr_done) state_next = LOAD;
            end
            LOAD: begin
                if (accept) begin
                    // Error outranks last: an illegal last beat ends in ERR.
                    if (!in_range || overflow) begin
                        state_next = ERR;
                    end else begin
                        do_write = !self_loop;
                        do_drop  = self_loop;
                        if (edge_last) state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            edge_ready <= 1'b0;
            we_e       <= 1'b0;
            addr_e     <= '0;
            din_ea     <= '0;
            din_eb     <= '0;
            edge_count <= '0;
            first_node <= '1;
            dropped    <= '0;
        end else begin
            state      <= state_next;
            edge_ready <= (state_next == LOAD);
            we_e       <= do_write;
            if (do_write) begin
                addr_e     <= edge_count;
                din_ea     <= edge_src;
                din_eb     <= edge_dst;
                edge_count <= edge_count + DW'(1);
                if (edge_count == '0) first_node <= edge_src;
            end
            if (do_drop) dropped <= dropped + DW'(1);
            // A new load starts from a clean set of results.
            if (clr_start) begin
                edge_count <= '0;
                dropped    <= '0;
                first_node <= '1;
            end
        end
    end

    assign we_ea     = we_e;
    assign we_eb     = we_e;
    assign din_pos   = NODE_NONE;
    assign din_grid  = NODE_NONE;
    assign busy      = (state == CLR) || (state == LOAD);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign fsm_state = state;

endmodule

// File: tb/tb_graph_loader.sv
// Testbench for graph_loader: directed and randomized edge lists are run
// through a list-level reference model that predicts the edge-memory writes
// and final results; a negedge monitor checks every write as it appears.
module tb_graph_loader;
    import placement_pkg::*;

    localparam int V          = 11;
    localparam int GRID_N     = 10;
    localparam int POS_N      = 1 << V;
    localparam int GRID_CELLS = GRID_N * GRID_N;
    localparam int DEPTH      = (POS_N > GRID_CELLS) ? POS_N : GRID_CELLS;
    localparam int W          = 1 + 3 * DW;   // {last, addr, src, dst}
`ifdef LOADER_SELFLOOP_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          edge_valid;
    logic          edge_ready;
    logic [DW-1:0] edge_src;
    logic [DW-1:0] edge_dst;
    logic          edge_last;
    logic          we_ea, we_eb;
    logic [DW-1:0] addr_e, din_ea, din_eb;
    logic          we_pos;
    logic [DW-1:0] addr_pos, din_pos;
    logic          we_grid;
    logic [DW-1:0] addr_grid, din_grid;
    logic          busy, done, error;
    logic [DW-1:0] edge_count, first_node, dropped;
    loader_state_e fsm_state;

    graph_loader #(.V(V), .GRID_N(GRID_N), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .edge_src   (edge_src),
        .edge_dst   (edge_dst),
        .edge_last  (edge_last),
        .we_ea      (we_ea),
        .we_eb      (we_eb),
        .addr_e     (addr_e),
        .din_ea     (din_ea),
        .din_eb     (din_eb),
        .we_pos     (we_pos),
        .addr_pos   (addr_pos),
        .din_pos    (din_pos),
        .we_grid    (we_grid),
        .addr_grid  (addr_grid),
        .din_grid   (din_grid),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .edge_count (edge_count),
        .first_node (first_node),
        .dropped    (dropped),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int pos_count  = 0;
    int grid_count = 0;

    // current edge list (stimulus)
    int bs[$];
    int bd[$];
    bit bl[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_pos = 1'b0;
    int   exp_k    = 0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (we_pos) begin
            exp_k = prev_pos ? exp_k + 1 : 0;
            pos_count++;
            check("pos_addr", addr_pos, DW'(exp_k));
            check("pos_data", din_pos, NODE_NONE);
        end
        prev_pos = we_pos;
        if (we_pos || we_grid) begin
            check("grid_we", DW'(we_grid), DW'(we_pos && (addr_pos < DW'(GRID_CELLS))));
            if (we_grid) begin
                grid_count++;
                check("grid_addr", addr_grid, addr_pos);
                check("grid_data", din_grid, NODE_NONE);
            end
        end
        if (we_ea || we_eb) begin
            check("we_pair", DW'({we_ea, we_eb}), DW'(2'b11));
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%0d src=%0d dst=%0d", addr_e, din_ea, din_eb);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", addr_e, e[3*DW-1:2*DW]);
                check("write_src", din_ea, e[2*DW-1:DW]);
                check("write_dst", din_eb, e[DW-1:0]);
                check("write_count", edge_count, e[3*DW-1:2*DW] + DW'(1));
                check("done_with_last", DW'(done), DW'(e[W-1]));
            end
        end
    end

    // ---------------- reference model ----------------
    // Walks the list by the loader's rules and queues every write it should make.
    task automatic model_list(output int n_drive, output int cnt, output int drop,
                              output int first, output bit err);
        cnt = 0; drop = 0; first = -1; err = 1'b0; n_drive = 0;
        for (int i = 0; i < bs.size(); i++) begin
            bit legal;
            n_drive = i + 1;
            legal = (bs[i] >= 0) && (bs[i] < POS_N) && (bd[i] >= 0) && (bd[i] < POS_N);
            if (!legal || cnt == POS_N) begin
                err = 1'b1;
                break;
            end
            if (DROP_EN && bs[i] == bd[i]) begin
                drop++;
            end else begin
                if (cnt == 0) first = bs[i];
                exp_q.push_back({bl[i], DW'(cnt), DW'(bs[i]), DW'(bd[i])});
                cnt++;
            end
            if (bl[i]) break;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_list();
        bs.delete(); bd.delete(); bl.delete();
    endtask

    task automatic add(input int s, input int d, input bit l);
        bs.push_back(s); bd.push_back(d); bl.push_back(l);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // Start a load and wait for LOAD; cycle 0 is the start cycle.
    task automatic begin_load();
        int cyc;
        pulse_start();
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", DW'(busy), 1);
        check("start_error_clr", DW'(error), 0);
        check("start_done_clr", DW'(done), 0);
        check("start_count_clr", edge_count, 0);
        check("start_dropped_clr", dropped, 0);
        check("start_first_clr", first_node, NODE_NONE);
        while (!edge_ready && cyc < DEPTH + 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("load_entry_cycle", DW'(cyc), DW'(DEPTH + 1));
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid
    task automatic drive_list(input int mode, input int n);
        bit phase = 1'b1;
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            int guard = 0;
            while (!acc) begin
                bit v, rdy;
                @(negedge clk);
                v = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
                phase = !phase;
                edge_valid = v;
                edge_src   = v ? DW'(bs[i]) : DW'($urandom);
                edge_dst   = v ? DW'(bd[i]) : DW'($urandom);
                edge_last  = v ? bl[i] : 1'($urandom_range(0, 1));
                rdy = edge_ready;
                @(posedge clk);
                acc = v && rdy;
                guard++;
                if (!acc && guard > 200) begin
                    total++;
                    bad++;
                    $display("FAIL beat_timeout index=%0d ready=%0d required=1", i, edge_ready);
                    i = n;
                    break;
                end
            end
        end
        @(negedge clk);
        edge_valid = 1'b0;
        edge_last  = 1'b0;
    endtask

    task automatic finish_list(input bit e_err, input int e_cnt, input int e_drop, input int e_first);
        int guard = 0;
        while (!done && !error && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("end_error", DW'(error), DW'(e_err));
        check("end_done", DW'(done), DW'(!e_err));
        check("end_edge_count", edge_count, DW'(e_cnt));
        check("end_dropped", dropped, DW'(e_drop));
        check("end_first_node", first_node, DW'(e_first));
        check("end_ready_low", DW'(edge_ready), 0);
        check("end_busy_low", DW'(busy), 0);
        check("exp_q_drained", DW'(exp_q.size()), 0);
    endtask

    task automatic run_list(input int mode);
        int n, cnt, drop, first;
        bit err;
        begin_load();
        model_list(n, cnt, drop, first, err);
        drive_list(mode, n);
        finish_list(err, cnt, drop, first);
    endtask

    task automatic random_list(input int len, input int bad_at);
        clear_list();
        for (int i = 0; i < len; i++) begin
            int s = int'($urandom_range(0, POS_N - 1));
            int d = ($urandom_range(0, 7) == 0) ? s : int'($urandom_range(0, POS_N - 1));
            if (i == bad_at) begin
                if ($urandom_range(0, 1) == 1) s = -int'($urandom_range(1, 1000));
                else d = POS_N + int'($urandom_range(0, 1000));
            end
            add(s, d, i == len - 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0, g0;
        int guard;
        start = 1'b0; edge_valid = 1'b0; edge_src = '0; edge_dst = '0; edge_last = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_edge_ready", DW'(edge_ready), 0);
        check("rst_we_ea", DW'(we_ea), 0);
        check("rst_we_pos", DW'(we_pos), 0);
        check("rst_we_grid", DW'(we_grid), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_done", DW'(done), 0);
        check("rst_error", DW'(error), 0);
        check("rst_edge_count", edge_count, 0);
        check("rst_first_node", first_node, NODE_NONE);
        check("rst_dropped", dropped, 0);
        check("rst_addr_e", addr_e, 0);
        check("rst_state", DW'(fsm_state), DW'(IDLE));
        reset = 1'b1;

        // Reset in the middle of the clear sweep.
        pulse_start();
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(we_pos && addr_pos == 100) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("mid_clr_reached_k100", addr_pos, 100);
        reset = 1'b0;
        #1;
        check("mid_rst_we_pos", DW'(we_pos), 0);
        check("mid_rst_we_grid", DW'(we_grid), 0);
        check("mid_rst_addr_pos", addr_pos, 0);
        check("mid_rst_busy", DW'(busy), 0);
        check("mid_rst_state", DW'(fsm_state), DW'(IDLE));
        @(negedge clk);
        reset = 1'b1;

        // Full sweep plus the directed stream with valid held.
        p0 = pos_count;
        g0 = grid_count;
        clear_list();
        add(3, 7, 1'b0); add(7, 1, 1'b0); add(1, 3, 1'b1);
        run_list(0);
        check("sweep_pos_writes", DW'(pos_count - p0), DW'(POS_N));
        check("sweep_grid_writes", DW'(grid_count - g0), DW'(GRID_CELLS));

        // Same list with valid toggling.
        run_list(1);

        // Random lists with random valid gaps.
        for (int r = 0; r < 4; r++) begin
            random_list(int'($urandom_range(4, 24)), -1);
            run_list(2);
        end

        // Destination out of range.
        clear_list();
        add(5, 2048, 1'b0);
        run_list(0);

        // Illegal beat in the middle of a random list.
        random_list(12, int'($urandom_range(2, 9)));
        run_list(2);

        // Self-loop followed by a normal last edge.
        clear_list();
        add(4, 4, 1'b0); add(4, 9, 1'b1);
        run_list(0);

        // Fill every edge slot, then one more beat overflows.
        clear_list();
        for (int i = 0; i < POS_N; i++) begin
            int s = int'($urandom_range(0, POS_N - 1));
            add(s, (s + 1 + int'($urandom_range(0, POS_N - 2))) % POS_N, 1'b0);
        end
        add(1, 2, 1'b1);
        run_list(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
